// File: rtl/six_step_commutator_if.sv
// Sector/drive bundle between sector logic, PWM source and one
// six-step commutator channel.
interface six_step_commutator_if;
  logic        enable;
  logic        sector_valid;
  logic [2:0]  sector;
  logic        dir;
  logic        pwm_in;
  logic        fault_clr;
  logic [2:0]  udrive;
  logic [2:0]  ldrive;
  logic        fault;
  logic        busy;
  logic [15:0] comm_count;

  modport master (
    output enable, sector_valid, sector, dir,
    output pwm_in, fault_clr,
    input  udrive, ldrive, fault, busy, comm_count
  );

  modport slave (
    input  enable, sector_valid, sector, dir,
    input  pwm_in, fault_clr,
    output udrive, ldrive, fault, busy, comm_count
  );
endinterface

// File: rtl/six_step_commutator.sv
// Six-step commutation controller: sector/dir to bridge gates,
// with a dead-time break between patterns and illegal-sector fault.
module six_step_commutator #(
  parameter int DEADTIME = 50,
  parameter int DT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  six_step_commutator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    DRIVE,
    FAULT
  } state_t;

  localparam logic [2:0] PH_A = 3'b100;
  localparam logic [2:0] PH_B = 3'b010;
  localparam logic [2:0] PH_C = 3'b001;
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

  state_t          state;
  logic [DT_W-1:0] dt_cnt;
  logic            tgt_v;
  logic [2:0]      tgt_hi, tgt_lo;
  logic [2:0]      app_hi, app_lo;
  logic [2:0]      tbl_hi, tbl_lo;
  logic [2:0]      fwd_hi, fwd_lo;
  logic [2:0]      u_q, l_q;
  logic            fault_q, busy_q;
  logic [15:0]     comm_q;
  logic            illegal, legal_ld, fault_exit, differs;

  assign illegal    = bus.sector_valid & bus.sector[2] & bus.sector[1];
  assign legal_ld   = bus.sector_valid & ~illegal;
  assign fault_exit = (state == FAULT) & bus.fault_clr & ~illegal;
  assign differs    = (tgt_hi != app_hi) | (tgt_lo != app_lo);

  // Forward sector table, reverse swaps the hi and lo phases
  always_comb begin
    fwd_hi = 3'b000;
    fwd_lo = 3'b000;
    case (bus.sector)
      3'd0: begin fwd_hi = PH_A; fwd_lo = PH_B; end
      3'd1: begin fwd_hi = PH_A; fwd_lo = PH_C; end
      3'd2: begin fwd_hi = PH_B; fwd_lo = PH_C; end
      3'd3: begin fwd_hi = PH_B; fwd_lo = PH_A; end
      3'd4: begin fwd_hi = PH_C; fwd_lo = PH_A; end
      3'd5: begin fwd_hi = PH_C; fwd_lo = PH_B; end
      default: ;
    endcase
    tbl_hi = bus.dir ? fwd_lo : fwd_hi;
    tbl_lo = bus.dir ? fwd_hi : fwd_lo;
  end

  // Target pattern; dropped on fault exit so a fresh sector is needed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_v  <= 1'b0;
      tgt_hi <= 3'b000;
      tgt_lo <= 3'b000;
    end else if (fault_exit) begin
      tgt_v  <= 1'b0;
    end else if (legal_ld) begin
      tgt_v  <= 1'b1;
      tgt_hi <= tbl_hi;
      tgt_lo <= tbl_lo;
    end
  end

  // Commutation FSM with registered gate outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dt_cnt  <= '0;
      app_hi  <= 3'b000;
      app_lo  <= 3'b000;
      u_q     <= 3'b000;
      l_q     <= 3'b000;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      comm_q  <= 16'h0000;
    end else if (illegal) begin
      state   <= FAULT;
      u_q     <= 3'b000;
      l_q     <= 3'b000;
      fault_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && tgt_v) begin
            state  <= BREAK;
            busy_q <= 1'b1;
            dt_cnt <= DT_LOAD;
          end
        end
        BREAK: begin
          if (!bus.enable) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (dt_cnt == '0) begin
            state  <= DRIVE;
            busy_q <= 1'b0;
            app_hi <= tgt_hi;
            app_lo <= tgt_lo;
            u_q    <= tgt_hi & {3{bus.pwm_in}};
            l_q    <= tgt_lo;
            comm_q <= comm_q + 16'd1;
          end else begin
            dt_cnt <= dt_cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (!bus.enable) begin
            state <= IDLE;
            u_q   <= 3'b000;
            l_q   <= 3'b000;
          end else if (differs) begin
            state  <= BREAK;
            u_q    <= 3'b000;
            l_q    <= 3'b000;
            busy_q <= 1'b1;
            dt_cnt <= DT_LOAD;
          end else begin
            u_q <= app_hi & {3{bus.pwm_in}};
          end
        end
        FAULT: begin
          if (bus.fault_clr) begin
            state   <= IDLE;
            fault_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.udrive     = u_q;
  assign bus.ldrive     = l_q;
  assign bus.fault      = fault_q;
  assign bus.busy       = busy_q;
  assign bus.comm_count = comm_q;

endmodule
